// File: rtl/rca_nibble_sequencer_if.sv
// rtl/rca_nibble_sequencer_if.sv - request/response and 4-bit adder bus of the nibble sequencer
// The sequencer takes the slave side; the host and external adder take the master side.
interface rca_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic [3:0]       rca_a;
  logic [3:0]       rca_b;
  logic             rca_cin;
  logic [3:0]       rca_sum;
  logic             rca_cout;

  modport slave (
    input  start, sub, op_a, op_b, cin, rca_sum, rca_cout,
    output busy, done, result, cout, overflow, rca_a, rca_b, rca_cin
  );

  modport master (
    output start, sub, op_a, op_b, cin, rca_sum, rca_cout,
    input  busy, done, result, cout, overflow, rca_a, rca_b, rca_cin
  );
endinterface

// File: rtl/rca_nibble_sequencer.sv
// rtl/rca_nibble_sequencer.sv - multi-cycle WIDTH-bit add/sub driving an external 4-bit ripple adder
// Operands are latched on start and fed LSB nibble first; carry is chained between passes.
module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  rca_nibble_sequencer_if.slave    bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] result_q;
  logic                    carry_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    cout_q;
  logic                    overflow_q;
  logic                    accept;
  logic                    last;

  assign accept = bus.start && (state != RUN);
  assign last   = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rca_a   = 4'h0;
    bus.rca_b   = 4'h0;
    bus.rca_cin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy    = 1'b1;
        bus.rca_a   = a_q[idx_q];
        bus.rca_b   = b_q[idx_q];
        bus.rca_cin = carry_q;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted at latch time and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.op_a;
      b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
      carry_q  <= bus.sub ? 1'b1 : bus.cin;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state == RUN) begin
      result_q[idx_q] <= bus.rca_sum;
      carry_q         <= bus.rca_cout;
      overflow_q      <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                         (bus.rca_sum[3] != a_q[NIBBLES-1][3]);
      if (last) cout_q <= bus.rca_cout;
      else      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// tb/tb_rca_nibble_sequencer.sv - scoreboard bench for rca_nibble_sequencer with a behavioural 4-bit adder
module tb_rca_nibble_sequencer;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic cin_log [4];
  int   lat_n;
  int   busy_cnt;

  rca_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  rca_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.rca_cout, bus.rca_sum} = bus.rca_a + bus.rca_b + bus.rca_cin;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {16'h0, bus.result}, {16'h0, e.result});
        chk("cout", {31'h0, bus.cout}, {31'h0, e.cout});
        chk("overflow", {31'h0, bus.overflow}, {31'h0, e.ovf});
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                        input logic [15:0] er, input logic ec, input logic ev, input logic scramble);
    sb_q.push_back('{result: er, cout: ec, ovf: ev});
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.op_a = ~a;
      bus.op_b = 16'h5A5A;
      bus.cin  = 1'b1;
      bus.sub  = ~s;
    end
    lat_n    = 0;
    busy_cnt = 0;
    while (!bus.done && lat_n < 20) begin
      if (bus.busy) busy_cnt++;
      if (lat_n < 4) cin_log[lat_n] = bus.rca_cin;
      @(posedge clk); #1;
      lat_n++;
    end
    chk("latency", lat_n, 4);
    chk("busy_cycles", busy_cnt, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    int d1, d2, n, gap_busy;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    #12;
    chk("rst_busy", {31'h0, bus.busy}, 0);
    chk("rst_done", {31'h0, bus.done}, 0);
    chk("rst_result", {16'h0, bus.result}, 0);
    chk("rst_cout_ovf", {30'h0, bus.cout, bus.overflow}, 0);
    chk("rst_rca", {23'h0, bus.rca_a, bus.rca_b, bus.rca_cin}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("ripple_cin", {28'h0, cin_log[3], cin_log[2], cin_log[1], cin_log[0]}, 32'hE);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back: start held high for the whole first operation.
    sb_q.push_back('{result: 16'h3333, cout: 1'b0, ovf: 1'b0});
    sb_q.push_back('{result: 16'h0000, cout: 1'b1, ovf: 1'b0});
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op_a = 16'hA000;
    bus.op_b = 16'h6000;
    d1 = -1;
    d2 = -1;
    gap_busy = 0;
    for (n = 0; n < 14; n++) begin
      if (bus.done && d1 < 0) d1 = n;
      else if (bus.done && d2 < 0) begin
        d2 = n;
        bus.start = 1'b0;
      end
      if (n == 5) gap_busy = bus.busy;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("b2b_done1", d1, 4);
    chk("b2b_done2", d2, 9);
    chk("b2b_no_gap", gap_busy, 1);
    @(posedge clk); #1;

    // Reset during the second RUN cycle aborts without a done pulse.
    bus.op_a  = 16'h00FF;
    bus.op_b  = 16'h0001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_busy", {31'h0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, bus.busy}, 0);
    chk("abort_done", {31'h0, bus.done}, 0);
    chk("abort_result", {16'h0, bus.result}, 0);
    chk("abort_rca", {23'h0, bus.rca_a, bus.rca_b, bus.rca_cin}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'h0, bus.done}, 0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
